// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline sequencer: FSM state codes, branch
// function-decode bit positions and the hard-wired zero register.
package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_BRANCH = 2'd1;
  localparam state_t ST_MULTI  = 2'd2;

  localparam int unsigned FUNC_BEQ  = 4;
  localparam int unsigned FUNC_BNE  = 3;
  localparam int unsigned FUNC_BGTZ = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sched_scoreboard.sv
// Register scoreboard: 2-bit pending-write count per architectural register,
// raising rs/rt hazards and flagging count overflow/underflow.
module sched_scoreboard
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_en,
  input  logic [4:0] inc_rw,
  input  logic       dec_en,
  input  logic [4:0] dec_rw,
  input  logic [4:0] rs,
  input  logic       uses_rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       rs_hazard,
  output logic       rt_hazard,
  output logic       err
);

  logic [1:0] cnt_q [32];
  logic [1:0] cnt_d [32];
  logic       inc_v;
  logic       dec_v;

  assign inc_v = inc_en && (inc_rw != REG_ZERO);
  assign dec_v = dec_en && (dec_rw != REG_ZERO);

  // Hazards look only at registered counts; a retire clears them a cycle later.
  assign rs_hazard = uses_rs && (rs != REG_ZERO) && (cnt_q[rs] != 2'd0);
  assign rt_hazard = uses_rt && (rt != REG_ZERO) && (cnt_q[rt] != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (!(inc_v && dec_v && (inc_rw == dec_rw))) begin
      if (inc_v) begin
        if (cnt_q[inc_rw] == 2'd3) err = 1'b1;
        else                       cnt_d[inc_rw] = cnt_q[inc_rw] + 2'd1;
      end
      if (dec_v) begin
        if (cnt_q[dec_rw] == 2'd0) err = 1'b1;
        else                       cnt_d[dec_rw] = cnt_q[dec_rw] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Central 5-stage pipeline sequencer: scoreboard data hazards, branch-shadow
// FSM with timeout, multicycle-EX hold, stall counter and sticky error.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int unsigned BR_TIMEOUT = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [14:0]      id_func,
  input  logic             id_multicycle,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwr,
  input  logic [4:0]       id_rw,
  input  logic             wb_regwr,
  input  logic [4:0]       wb_rw,
  input  logic             br_resolved,
  input  logic             br_taken,
  input  logic             mc_done,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic             if_flush,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err
);

  localparam int unsigned TW = $clog2(BR_TIMEOUT) + 1;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] stall_q;
  logic             err_q;
  logic             err_set;
  logic             rs_hazard, rt_hazard, hazard;
  logic             sb_err;
  logic             issue;
  logic             is_branch;
  logic             unused_func;

  assign unused_func = ^{id_func[14:5], id_func[1:0]};
  assign is_branch   = id_func[FUNC_BEQ] | id_func[FUNC_BNE] | id_func[FUNC_BGTZ];
  assign hazard      = rs_hazard | rt_hazard;
  assign issue       = id_valid && !hazard && (state_q == ST_RUN);

  sched_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (issue && id_regwr),
    .inc_rw    (id_rw),
    .dec_en    (wb_regwr),
    .dec_rw    (wb_rw),
    .rs        (id_rs),
    .uses_rs   (id_uses_rs),
    .rt        (id_rt),
    .uses_rt   (id_uses_rt),
    .rs_hazard (rs_hazard),
    .rt_hazard (rt_hazard),
    .err       (sb_err)
  );

  always_comb begin
    if_en       = 1'b1;
    id_en       = 1'b1;
    ex_bubble   = 1'b0;
    ex_hold     = 1'b0;
    if_flush    = 1'b0;
    pc_redirect = 1'b0;
    state_d     = state_q;
    timer_d     = timer_q;
    err_set     = sb_err;
    case (state_q)
      ST_RUN: begin
        if (id_valid && hazard) begin
          if_en     = 1'b0;
          id_en     = 1'b0;
          ex_bubble = 1'b1;
        end else if (issue && is_branch) begin
          if_en   = 1'b0;
          state_d = ST_BRANCH;
          timer_d = '0;
        end else if (issue && id_multicycle) begin
          state_d = ST_MULTI;
        end
        if (mc_done) err_set = 1'b1;
      end
      ST_BRANCH: begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_bubble = 1'b1;
        if (br_resolved) begin
          if_en   = 1'b1;
          state_d = ST_RUN;
          if (br_taken) begin
            pc_redirect = 1'b1;
            if_flush    = 1'b1;
          end
        end else if (timer_q == TW'(BR_TIMEOUT - 1)) begin
          // Last allowed shadow cycle: give up without redirecting.
          err_set = 1'b1;
          state_d = ST_RUN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (mc_done) err_set = 1'b1;
      end
      ST_MULTI: begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        ex_hold = 1'b1;
        if (mc_done) begin
          ex_hold = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Reset overrides live inputs so the pipeline sees a clean free-run.
    if (!rst_n) begin
      if_en       = 1'b1;
      id_en       = 1'b1;
      ex_bubble   = 1'b0;
      ex_hold     = 1'b0;
      if_flush    = 1'b0;
      pc_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (!if_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched: reset, hazards, branches,
// timeout, multicycle hold, r0, mid-operation reset and scoreboard overflow.
module tb_pipe_sched;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [14:0] id_func;
  logic        id_multicycle;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        id_regwr;
  logic [4:0]  id_rw;
  logic        wb_regwr;
  logic [4:0]  wb_rw;
  logic        br_resolved, br_taken, mc_done;
  logic        if_en, id_en, ex_bubble, ex_hold, if_flush, pc_redirect;
  logic [15:0] stall_cycles;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_sched #(.BR_TIMEOUT(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_func       (id_func),
    .id_multicycle (id_multicycle),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_regwr      (id_regwr),
    .id_rw         (id_rw),
    .wb_regwr      (wb_regwr),
    .wb_rw         (wb_rw),
    .br_resolved   (br_resolved),
    .br_taken      (br_taken),
    .mc_done       (mc_done),
    .if_en         (if_en),
    .id_en         (id_en),
    .ex_bubble     (ex_bubble),
    .ex_hold       (ex_hold),
    .if_flush      (if_flush),
    .pc_redirect   (pc_redirect),
    .stall_cycles  (stall_cycles),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    id_valid = 0; id_func = '0; id_multicycle = 0; id_rs = '0; id_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_regwr = 0; id_rw = '0; wb_regwr = 0;
    wb_rw = '0; br_resolved = 0; br_taken = 0; mc_done = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    id_valid = 1; id_func = 15'h0010;
    repeat (2) @(posedge clk);
    settle();
    n_tests++;
    if ({if_en, id_en, ex_bubble, ex_hold, if_flush, pc_redirect} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 110000",
               {if_en, id_en, ex_bubble, ex_hold, if_flush, pc_redirect});
    end
    adv();
    rst_n = 1;
    idle();
    settle();
    n_tests++;
    if ({if_en, id_en} !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_en: got %b want 11", {if_en, id_en});
    end
    n_tests++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_stall: got %0d want 0", stall_cycles);
    end
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_err: got %b want 0", err);
    end
    adv();
    id_valid = 1; id_regwr = 1; id_rw = 5'd5;
    settle();
    n_tests++;
    if (if_en !== 1'b1) begin
      n_fail++; $display("FAIL issue_r5: got if_en=%b want 1", if_en);
    end
    adv();
    idle(); id_valid = 1; id_rs = 5'd5; id_uses_rs = 1;
    settle();
    n_tests++;
    if ({if_en, id_en, ex_bubble} !== 3'b001) begin
      n_fail++;
      $display("FAIL rs_stall: got if/id/bubble=%b want 001", {if_en, id_en, ex_bubble});
    end
    adv();
    idle(); id_valid = 1; id_rt = 5'd5; id_uses_rt = 1;
    settle();
    n_tests++;
    if ({if_en, ex_bubble} !== 2'b01) begin
      n_fail++; $display("FAIL rt_stall: got if/bubble=%b want 01", {if_en, ex_bubble});
    end
    adv();
    idle(); id_valid = 1; id_rs = 5'd5; id_uses_rs = 0;
    settle();
    n_tests++;
    if ({if_en, ex_bubble} !== 2'b10) begin
      n_fail++;
      $display("FAIL unused_rs_no_stall: got if/bubble=%b want 10", {if_en, ex_bubble});
    end
    adv();
    idle();
  endtask

  task automatic test_hazard_clear();
    do_reset();
    id_valid = 1; id_regwr = 1; id_rw = 5'd7;
    adv();
    idle(); id_valid = 1; id_rs = 5'd7; id_uses_rs = 1;
    settle();
    n_tests++;
    if (if_en !== 1'b0) begin
      n_fail++; $display("FAIL hz_stall_before_retire: got %b want 0", if_en);
    end
    adv();
    wb_regwr = 1; wb_rw = 5'd7;
    settle();
    n_tests++;
    if ({if_en, ex_bubble} !== 2'b01) begin
      n_fail++; $display("FAIL hz_stall_retire_cycle: got %b want 01", {if_en, ex_bubble});
    end
    adv();
    wb_regwr = 0; wb_rw = '0;
    settle();
    n_tests++;
    if ({if_en, id_en, ex_bubble} !== 3'b110) begin
      n_fail++; $display("FAIL hz_issue_after_retire: got %b want 110", {if_en, id_en, ex_bubble});
    end
    adv();
    idle();
    settle();
    n_tests++;
    if (stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL hz_stall_count: got %0d want 2", stall_cycles);
    end
    adv();
  endtask

  task automatic test_branch();
    do_reset();
    id_valid = 1; id_func = 15'h0010;
    settle();
    n_tests++;
    if ({if_en, id_en, pc_redirect} !== 3'b010) begin
      n_fail++; $display("FAIL br_issue: got if/id/redir=%b want 010", {if_en, id_en, pc_redirect});
    end
    adv();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if ({if_en, id_en, ex_bubble, pc_redirect, if_flush} !== 5'b00100) begin
        n_fail++;
        $display("FAIL br_shadow_%0d: got %b want 00100", i,
                 {if_en, id_en, ex_bubble, pc_redirect, if_flush});
      end
      adv();
    end
    br_resolved = 1; br_taken = 1;
    settle();
    n_tests++;
    if ({if_en, pc_redirect, if_flush} !== 3'b111) begin
      n_fail++;
      $display("FAIL br_taken_redirect: got if/redir/flush=%b want 111",
               {if_en, pc_redirect, if_flush});
    end
    adv();
    idle();
    settle();
    n_tests++;
    if ({if_en, pc_redirect, if_flush} !== 3'b100) begin
      n_fail++;
      $display("FAIL br_redirect_one_cycle: got %b want 100", {if_en, pc_redirect, if_flush});
    end
    n_tests++;
    if (stall_cycles !== 16'd4) begin
      n_fail++; $display("FAIL br_stall_count: got %0d want 4", stall_cycles);
    end
    adv();
    // Not-taken bne resolved on the first shadow cycle.
    id_valid = 1; id_func = 15'h0008;
    adv();
    idle(); br_resolved = 1; br_taken = 0;
    settle();
    n_tests++;
    if ({if_en, pc_redirect, if_flush} !== 3'b100) begin
      n_fail++;
      $display("FAIL br_not_taken: got if/redir/flush=%b want 100", {if_en, pc_redirect, if_flush});
    end
    adv();
    idle();
    settle();
    n_tests++;
    if (stall_cycles !== 16'd5 || err !== 1'b0) begin
      n_fail++; $display("FAIL br_nt_stall_err: got %0d/%b want 5/0", stall_cycles, err);
    end
    adv();
  endtask

  task automatic test_branch_timeout();
    do_reset();
    id_valid = 1; id_func = 15'h0004;
    adv();
    idle();
    for (int i = 0; i < 8; i++) begin
      settle();
      n_tests++;
      if ({if_en, pc_redirect, err} !== 3'b000) begin
        n_fail++;
        $display("FAIL bto_cycle_%0d: got if/redir/err=%b want 000", i, {if_en, pc_redirect, err});
      end
      adv();
    end
    settle();
    n_tests++;
    if ({err, if_en, pc_redirect, ex_bubble} !== 4'b1100) begin
      n_fail++;
      $display("FAIL bto_expire: got err/if/redir/bubble=%b want 1100",
               {err, if_en, pc_redirect, ex_bubble});
    end
    n_tests++;
    if (stall_cycles !== 16'd9) begin
      n_fail++; $display("FAIL bto_stall_count: got %0d want 9", stall_cycles);
    end
    adv();
  endtask

  task automatic test_multicycle();
    do_reset();
    id_valid = 1; id_multicycle = 1;
    settle();
    n_tests++;
    if ({if_en, id_en, ex_hold} !== 3'b110) begin
      n_fail++; $display("FAIL mc_issue: got if/id/hold=%b want 110", {if_en, id_en, ex_hold});
    end
    adv();
    idle();
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if ({if_en, id_en, ex_hold} !== 3'b001) begin
        n_fail++; $display("FAIL mc_hold_%0d: got %b want 001", i, {if_en, id_en, ex_hold});
      end
      adv();
    end
    mc_done = 1;
    settle();
    n_tests++;
    if ({if_en, ex_hold} !== 2'b00) begin
      n_fail++; $display("FAIL mc_done_cycle: got if/hold=%b want 00", {if_en, ex_hold});
    end
    adv();
    idle(); id_valid = 1; id_regwr = 1; id_rw = 5'd0;
    settle();
    n_tests++;
    if ({if_en, ex_hold, err} !== 3'b100) begin
      n_fail++; $display("FAIL mc_back_to_run: got if/hold/err=%b want 100", {if_en, ex_hold, err});
    end
    adv();
    idle(); id_valid = 1; id_rs = 5'd0; id_uses_rs = 1; id_rt = 5'd0; id_uses_rt = 1;
    settle();
    n_tests++;
    if ({if_en, ex_bubble} !== 2'b10) begin
      n_fail++; $display("FAIL r0_no_stall: got if/bubble=%b want 10", {if_en, ex_bubble});
    end
    adv();
    idle(); mc_done = 1;
    adv();
    idle();
    settle();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL mc_done_in_run_err: got %b want 1", err);
    end
    adv();
  endtask

  task automatic test_reset_mid_op_overflow();
    do_reset();
    id_valid = 1; id_multicycle = 1;
    adv();
    settle();
    n_tests++;
    if (ex_hold !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_in_multi: got hold=%b want 1", ex_hold);
    end
    rst_n = 0;
    #1;
    n_tests++;
    if ({if_en, id_en, ex_hold, ex_bubble} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b want 1100", {if_en, id_en, ex_hold, ex_bubble});
    end
    @(posedge clk);
    #1 rst_n = 1;
    idle();
    for (int i = 0; i < 4; i++) begin
      idle(); id_valid = 1; id_regwr = 1; id_rw = 5'd9;
      settle();
      if (i == 3) begin
        n_tests++;
        if ({if_en, err} !== 2'b10) begin
          n_fail++; $display("FAIL ovf_before_fourth: got if/err=%b want 10", {if_en, err});
        end
      end
      adv();
    end
    idle(); id_valid = 1; id_rs = 5'd9; id_uses_rs = 1;
    settle();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_err: got %b want 1", err);
    end
    n_tests++;
    if (if_en !== 1'b0) begin
      n_fail++; $display("FAIL ovf_count_held_stall: got if_en=%b want 0", if_en);
    end
    adv();
    for (int i = 0; i < 3; i++) begin
      idle(); wb_regwr = 1; wb_rw = 5'd9;
      adv();
    end
    idle(); id_valid = 1; id_rs = 5'd9; id_uses_rs = 1;
    settle();
    n_tests++;
    if (if_en !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained: got if_en=%b want 1", if_en);
    end
    adv();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_hazard_clear();
    test_branch();
    test_branch_timeout();
    test_multicycle();
    test_reset_mid_op_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WR).
- Replaces per-stage stall glue with three parts: a register scoreboard (data hazards), a branch-shadow FSM, and a multicycle-EX busy handshake.
- Drives the IF/ID enables, EX bubble/hold, and branch redirect/flush. Sits beside the ID stage and consumes ID decode plus WR/EX status.

Parameters:
- BR_TIMEOUT, 8, max cycles in BRANCH awaiting br_resolved before err asserts.
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction in ID
- id_func  in  15  one-hot ID function decode; bit4 beq, bit3 bne, bit2 bgtz
- id_multicycle  in  1  ID instruction uses multicycle EX unit
- id_rs, id_rt  in  5  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_regwr  in  1  ID instruction writes a register
- id_rw  in  5  ID destination register
- wb_regwr  in  1  WR stage writing register file this cycle
- wb_rw  in  5  WR destination register
- br_resolved  in  1  branch outcome valid (EX)
- br_taken  in  1  branch outcome, qualified by br_resolved
- mc_done  in  1  multicycle unit finished (1-cycle pulse)
- if_en  out  1  PC/IF register enable
- id_en  out  1  IF/ID register enable
- ex_bubble  out  1  load NOP into ID/EX
- ex_hold  out  1  freeze ID/EX and EX/MEM
- if_flush  out  1  squash IF/ID contents
- pc_redirect  out  1  select branch target into PC
- stall_cycles  out  CNT_W  saturating count of cycles with if_en=0
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=RUN, all scoreboard counts=0, br timer=0, stall_cycles=0, err=0.
- Output values while in reset: if_en=1, id_en=1, ex_bubble=0, ex_hold=0, if_flush=0, pc_redirect=0. Reset mid-BRANCH/MULTI abandons the operation with no redirect.
- Scoreboard: 32 × 2-bit pending-write counts; r0 is never tracked.
  - issue = id_valid & ~hazard & state==RUN.
  - Increment cnt[id_rw] on issue & id_regwr & id_rw≠0.
  - Decrement cnt[wb_rw] on wb_regwr & wb_rw≠0.
  - Same register incremented and decremented in one cycle: unchanged.
  - Increment at 3, or decrement at 0: count held, err set.
- hazard = (id_uses_rs & id_rs≠0 & cnt[id_rs]≠0) | (id_uses_rt & id_rt≠0 & cnt[id_rt]≠0). Uses registered counts; no same-cycle WR bypass, so a retire clears the hazard one cycle later.
- is_branch = |id_func[4:2].
- Outputs are combinational from state and inputs; state and counters are registered.
- RUN:
  - id_valid & hazard: if_en=0, id_en=0, ex_bubble=1; stay in RUN. Hazard has priority over branch/multicycle.
  - issue & is_branch: if_en=0, id_en=1; next state BRANCH, timer=0.
  - issue & id_multicycle: id_en=1, if_en=1; next state MULTI.
  - Otherwise: if_en=1, id_en=1.
- BRANCH:
  - Each cycle: if_en=0, id_en=0, ex_bubble=1; timer increments.
  - br_resolved & br_taken: pc_redirect=1, if_flush=1, if_en=1 that cycle; next RUN.
  - br_resolved & ~br_taken: if_en=1; next RUN.
  - timer reaches BR_TIMEOUT: err=1, next RUN, no redirect.
- MULTI:
  - Each cycle: if_en=0, id_en=0, ex_hold=1.
  - mc_done: ex_hold=0 that cycle; next RUN.
  - mc_done seen in RUN or BRANCH: err=1, ignored.
- stall_cycles increments on every cycle with if_en=0 after reset; saturates at all-ones.
- err clears only on reset.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, BRANCH, MULTI};
  - FUNC_BEQ=4, FUNC_BNE=3, FUNC_BGTZ=2;
  - REG_ZERO=5'd0.
- One sub-module: sched_scoreboard, containing the counts, inc/dec logic, the rs/rt hazard outputs and the overflow/underflow error.

Test Plan:
- Reset check: hold rst_n=0 with clk running, then release → if_en=1, id_en=1, stall_cycles=0, err=0. Then issue id_rw=5 → next cycle, id_rs=5 with id_uses_rs=1 stalls (if_en=0, ex_bubble=1).
- Hazard clear timing: issue id_rw=7; retire with wb_rw=7, wb_regwr=1 at cycle N while ID holds id_rs=7 → stall through cycle N, issue at N+1.
- Taken branch: id_func=15'h0010 issued → BRANCH; br_resolved=1, br_taken=1 three cycles later → pc_redirect=1 and if_flush=1 for exactly one cycle; stall_cycles=4.
- Branch timeout: branch issued, br_resolved never asserted → err=1 after 8 BRANCH cycles, return to RUN, pc_redirect stays 0.
- Multicycle and r0: id_multicycle issued, mc_done pulse 5 cycles later → ex_hold=1 for 4 cycles, 0 on the done cycle. Separately, id_rw=0 issued with id_rs=0 following → no stall.
- Reset mid-operation and overflow: rst_n asserted mid-MULTI → outputs return to reset values immediately. Four issues to reg 9 with no retire → err=1 on the fourth, count stays 3.
